// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types for the master/slave bus interconnect.
//   ttype_e    : transfer direction (READ/WRITE)
//   tsize_e    : transfer size (BYTE/HALFWORD/WORD)
//   ic_state_e : interconnect transaction FSM states
//   idx_w()    : index width for an N-entry vector (at least 1 bit)
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } tsize_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        ERR  = 3'd3,
        RESP = 3'd4
    } ic_state_e;

    // Width of an index into an n-entry vector; a single entry still needs 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at
// (last + 1) mod N and the first requester found wins. The pointer register
// lives in the parent so it only advances when a transaction completes.
// Ports:
//   req     in  [N]  : request vector
//   last    in  [IW] : index of the previous grant
//   gnt     out [N]  : one-hot grant
//   gnt_idx out [IW] : grant index (0 when nothing requests)
//   any     out 1    : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import bus_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] cand_s;
    logic          take_s;
    logic          found_s;

    // Rotating priority search: offsets 1..N from the last grant, first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = '0;
        take_s  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s       = IW'((int'(last) + k) % N);
            take_s       = req[cand_s] & ~found_s;
            gnt[cand_s]  = gnt[cand_s] | take_s;
            gnt_idx      = take_s ? cand_s : gnt_idx;
            found_s      = found_s | take_s;
        end
        any = |req;
    end

endmodule

// File: rtl/bus_interconnect_mn.sv
// -----------------------------------------------------------------------------
// bus_interconnect_mn
// Shared-bus interconnect: N_MASTERS masters, N_SLAVES slaves, one transaction
// in flight. Round-robin arbitration, base/mask address decode (lowest matching
// slave wins) and an error response for unmapped addresses.
// Optional feature macro: BUS_TIMEOUT_EN -- WAIT watchdog of TIMEOUT_CYCLES
// cycles that completes the transaction with m_berr when the slave is silent.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   m_bstart [NM]       : request level per master, held until m_bdone
//   m_addr/m_ttype/m_tsize/m_wdata : per-master request
//   m_rdata  [NM][DW]   : read data, valid with m_bdone (0 for writes/errors)
//   m_bdone  [NM]       : one-cycle completion pulse
//   m_berr   [NM]       : error flag qualified by m_bdone
//   s_ss     [NS]       : one-hot slave select, held through the access
//   s_bstart            : one-cycle start pulse
//   s_addr/s_ttype/s_tsize/s_wdata : latched request broadcast to slaves
//   s_rdata  [NS][DW]   : slave read data
//   s_bdone  [NS]       : slave completion (only the selected one is used)
// -----------------------------------------------------------------------------
module bus_interconnect_mn
    import bus_pkg::*;
#(
    parameter int                N_MASTERS      = 2,
    parameter int                N_SLAVES       = 2,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] SLAVE_BASE [N_SLAVES] = '{32'h0000_0000, 32'hF000_0000},
    parameter logic [ADDR_W-1:0] SLAVE_MASK [N_SLAVES] = '{32'hF000_0000, 32'hF000_0000},
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_MASTERS-1:0]              m_bstart,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0]  m_addr,
    input  logic [N_MASTERS-1:0]              m_ttype,
    input  logic [N_MASTERS-1:0][1:0]         m_tsize,
    input  logic [N_MASTERS-1:0][DATA_W-1:0]  m_wdata,
    output logic [N_MASTERS-1:0][DATA_W-1:0]  m_rdata,
    output logic [N_MASTERS-1:0]              m_bdone,
    output logic [N_MASTERS-1:0]              m_berr,
    output logic [N_SLAVES-1:0]               s_ss,
    output logic                              s_bstart,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic                              s_ttype,
    output logic [1:0]                        s_tsize,
    output logic [DATA_W-1:0]                 s_wdata,
    input  logic [N_SLAVES-1:0][DATA_W-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]               s_bdone
);

    localparam int MW = idx_w(N_MASTERS);
    localparam int SW = idx_w(N_SLAVES);

    ic_state_e             state_r;
    ic_state_e             state_s;
    logic [MW-1:0]         last_ptr_r;
    logic [MW-1:0]         gnt_idx_r;
    logic [SW-1:0]         sel_idx_r;

    logic [N_MASTERS-1:0]  arb_gnt_unused_s;
    logic [MW-1:0]         arb_idx_s;
    logic                  arb_any_s;

    logic [ADDR_W-1:0]     win_addr_s;
    logic                  hit_s;
    logic                  dec_hit_s;
    logic [SW-1:0]         dec_idx_s;
    logic [N_SLAVES-1:0]   dec_oh_s;

    logic                  sel_done_s;
    logic                  tmo_s;
    logic                  resp_berr_s;
    logic [DATA_W-1:0]     resp_data_s;

    rr_arbiter #(
        .N (N_MASTERS)
    ) u_arb (
        .req     (m_bstart),
        .last    (last_ptr_r),
        .gnt     (arb_gnt_unused_s),
        .gnt_idx (arb_idx_s),
        .any     (arb_any_s)
    );

    // Address decode of the arbitration winner; descending scan so the lowest match wins.
    always_comb begin
        win_addr_s = m_addr[arb_idx_s];
        dec_hit_s  = 1'b0;
        dec_idx_s  = '0;
        hit_s      = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            hit_s     = ((win_addr_s & SLAVE_MASK[i]) == SLAVE_BASE[i]);
            dec_idx_s = hit_s ? SW'(i) : dec_idx_s;
            dec_hit_s = dec_hit_s | hit_s;
        end
        dec_oh_s            = '0;
        dec_oh_s[dec_idx_s] = dec_hit_s;
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_r;

    // Watchdog: cleared while the start pulse is out, counts every WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r == REQ) begin
            tmo_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Last WAIT cycle before the limit: leave on the next edge with an error.
    assign tmo_s = (state_r == WAIT) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    logic tmo_cfg_unused_s;
    assign tmo_s            = 1'b0;
    assign tmo_cfg_unused_s = (TIMEOUT_CYCLES > 0);
`endif

    // Response selection: a real slave completion in REQ/WAIT, otherwise an error (decode miss or timeout).
    always_comb begin
        sel_done_s  = s_bdone[sel_idx_r];
        resp_berr_s = 1'b1;
        resp_data_s = '0;
        if (((state_r == REQ) || (state_r == WAIT)) && sel_done_s) begin
            resp_berr_s = 1'b0;
            resp_data_s = (s_ttype == WRITE) ? '0 : s_rdata[sel_idx_r];
        end else begin
            resp_berr_s = 1'b1;
            resp_data_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; s_bdone in REQ skips WAIT entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = arb_any_s ? (dec_hit_s ? REQ : ERR) : IDLE;
            REQ:     state_s = sel_done_s ? RESP : WAIT;
            WAIT:    state_s = (sel_done_s || tmo_s) ? RESP : WAIT;
            ERR:     state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Registered datapath: request latch at grant, response at entry to RESP, cleanup in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr_r <= MW'(N_MASTERS - 1);
            gnt_idx_r  <= '0;
            sel_idx_r  <= '0;
            s_ss       <= '0;
            s_bstart   <= 1'b0;
            s_addr     <= '0;
            s_ttype    <= 1'b0;
            s_tsize    <= 2'd0;
            s_wdata    <= '0;
            m_rdata    <= '0;
            m_bdone    <= '0;
            m_berr     <= '0;
        end else begin
            s_bstart <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        gnt_idx_r <= arb_idx_s;
                        sel_idx_r <= dec_idx_s;
                        s_addr    <= win_addr_s;
                        s_ttype   <= m_ttype[arb_idx_s];
                        s_tsize   <= m_tsize[arb_idx_s];
                        s_wdata   <= m_wdata[arb_idx_s];
                        s_ss      <= dec_oh_s;
                        s_bstart  <= dec_hit_s;
                    end
                end
                REQ, WAIT, ERR: begin
                    if (state_s == RESP) begin
                        s_ss               <= '0;
                        m_bdone[gnt_idx_r] <= 1'b1;
                        m_berr[gnt_idx_r]  <= resp_berr_s;
                        m_rdata[gnt_idx_r] <= resp_data_s;
                    end
                end
                RESP: begin
                    m_bdone    <= '0;
                    m_berr     <= '0;
                    m_rdata    <= '0;
                    last_ptr_r <= gnt_idx_r;
                end
                default: begin
                    s_ss <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interconnect_mn.sv
// -----------------------------------------------------------------------------
// tb_bus_interconnect_mn
// Directed bench for bus_interconnect_mn with default parameters (2 masters,
// slave 0 at 0x0xxx_xxxx, slave 1 at 0xFxxx_xxxx). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_bus_interconnect_mn;

    logic              clk;
    logic              rst;
    logic [1:0]        m_bstart;
    logic [1:0][31:0]  m_addr;
    logic [1:0]        m_ttype;
    logic [1:0][1:0]   m_tsize;
    logic [1:0][31:0]  m_wdata;
    logic [1:0][31:0]  m_rdata;
    logic [1:0]        m_bdone;
    logic [1:0]        m_berr;
    logic [1:0]        s_ss;
    logic              s_bstart;
    logic [31:0]       s_addr;
    logic              s_ttype;
    logic [1:0]        s_tsize;
    logic [31:0]       s_wdata;
    logic [1:0][31:0]  s_rdata;
    logic [1:0]        s_bdone;

    int checks   = 0;
    int failures = 0;

    bus_interconnect_mn dut (
        .clk      (clk),
        .rst      (rst),
        .m_bstart (m_bstart),
        .m_addr   (m_addr),
        .m_ttype  (m_ttype),
        .m_tsize  (m_tsize),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_bdone  (m_bdone),
        .m_berr   (m_berr),
        .s_ss     (s_ss),
        .s_bstart (s_bstart),
        .s_addr   (s_addr),
        .s_ttype  (s_ttype),
        .s_tsize  (s_tsize),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .s_bdone  (s_bdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m_rdata"},  m_rdata,          64'd0);
        chk({tag, "_m_bdone"},  64'(m_bdone),     64'd0);
        chk({tag, "_m_berr"},   64'(m_berr),      64'd0);
        chk({tag, "_s_ss"},     64'(s_ss),        64'd0);
        chk({tag, "_s_bstart"}, 64'(s_bstart),    64'd0);
        chk({tag, "_s_addr"},   64'(s_addr),      64'd0);
        chk({tag, "_s_ttype"},  64'(s_ttype),     64'd0);
        chk({tag, "_s_tsize"},  64'(s_tsize),     64'd0);
        chk({tag, "_s_wdata"},  64'(s_wdata),     64'd0);
    endtask

    initial begin
        logic [63:0] exp_rd;
        int          exp_m;

        rst      = 1'b1;
        m_bstart = '0;
        m_addr   = '0;
        m_ttype  = '0;
        m_tsize  = '0;
        m_wdata  = '0;
        s_rdata  = '0;
        s_bdone  = '0;
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Zero-wait read by master 0 from slave 1.
        m_bstart[0] = 1'b1;
        m_addr[0]   = 32'hF000_0010;
        m_ttype[0]  = 1'b0;
        m_tsize[0]  = 2'd2;
        s_rdata[1]  = 32'hDEAD_BEEF;
        step();
        chk("t1_s_bstart", 64'(s_bstart), 64'd1);
        chk("t1_s_ss",     64'(s_ss),     64'd2);
        chk("t1_s_addr",   64'(s_addr),   64'hF000_0010);
        chk("t1_s_tsize",  64'(s_tsize),  64'd2);
        chk("t1_no_bdone", 64'(m_bdone),  64'd0);
        s_bdone[1] = 1'b1;
        step();
        chk("t1_m_bdone",  64'(m_bdone),  64'd1);
        chk("t1_m_rdata",  m_rdata,       {32'h0, 32'hDEAD_BEEF});
        chk("t1_m_berr",   64'(m_berr),   64'd0);
        chk("t1_ss_drop",  64'(s_ss),     64'd0);
        chk("t1_bst_low",  64'(s_bstart), 64'd0);
        s_bdone     = '0;
        m_bstart[0] = 1'b0;
        step();
        chk("t1_bdone_end", 64'(m_bdone), 64'd0);
        chk("t1_rdata_end", m_rdata,      64'd0);

        // Decode error: 0x8000_0000 matches no slave.
        m_bstart[0] = 1'b1;
        m_addr[0]   = 32'h8000_0000;
        step();
        chk("t2_s_ss",     64'(s_ss),     64'd0);
        chk("t2_s_bstart", 64'(s_bstart), 64'd0);
        chk("t2_no_bdone", 64'(m_bdone),  64'd0);
        step();
        chk("t2_m_bdone",  64'(m_bdone),  64'd1);
        chk("t2_m_berr",   64'(m_berr),   64'd1);
        chk("t2_m_rdata",  m_rdata,       64'd0);
        m_bstart[0] = 1'b0;
        step();

        // Write by master 1 to slave 0, two wait states, stray done from slave 1,
        // master drops its request after grant.
        m_bstart[1] = 1'b1;
        m_addr[1]   = 32'h0000_0004;
        m_ttype[1]  = 1'b1;
        m_tsize[1]  = 2'd1;
        m_wdata[1]  = 32'h0000_A5A5;
        s_rdata[0]  = 32'h1234_5678;
        step();
        chk("t3_s_bstart", 64'(s_bstart), 64'd1);
        chk("t3_s_ss",     64'(s_ss),     64'd1);
        chk("t3_s_addr",   64'(s_addr),   64'h4);
        chk("t3_s_wdata",  64'(s_wdata),  64'hA5A5);
        chk("t3_s_tsize",  64'(s_tsize),  64'd1);
        chk("t3_s_ttype",  64'(s_ttype),  64'd1);
        s_bdone[1]  = 1'b1;
        m_bstart[1] = 1'b0;
        step();
        chk("t3_w1_bstart", 64'(s_bstart), 64'd0);
        chk("t3_w1_ss",     64'(s_ss),     64'd1);
        chk("t3_w1_addr",   64'(s_addr),   64'h4);
        chk("t3_w1_wdata",  64'(s_wdata),  64'hA5A5);
        chk("t3_stray",     64'(m_bdone),  64'd0);
        s_bdone[1] = 1'b0;
        step();
        chk("t3_w2_ss",     64'(s_ss),     64'd1);
        chk("t3_w2_wdata",  64'(s_wdata),  64'hA5A5);
        chk("t3_w2_tsize",  64'(s_tsize),  64'd1);
        chk("t3_w2_bdone",  64'(m_bdone),  64'd0);
        s_bdone[0] = 1'b1;
        step();
        chk("t3_m_bdone",   64'(m_bdone),  64'd2);
        chk("t3_m_berr",    64'(m_berr),   64'd0);
        chk("t3_m_rdata",   m_rdata,       64'd0);
        s_bdone = '0;
        step();

        // Round-robin: both masters request continuously, one wait state each.
        m_bstart   = 2'b11;
        m_addr[0]  = 32'hF000_0100;
        m_addr[1]  = 32'hF000_0200;
        m_ttype    = 2'b00;
        m_tsize[0] = 2'd2;
        m_tsize[1] = 2'd2;
        for (int t = 0; t < 4; t++) begin
            exp_m = t % 2;
            step();
            chk($sformatf("t4_ss_%0d", t),   64'(s_ss),   64'd2);
            chk($sformatf("t4_addr_%0d", t), 64'(s_addr), (exp_m == 1) ? 64'hF000_0200 : 64'hF000_0100);
            s_rdata[1] = 32'h1000_0000 + 32'(t);
            step();
            chk($sformatf("t4_wait_%0d", t), 64'(m_bdone), 64'd0);
            s_bdone[1] = 1'b1;
            step();
            s_bdone[1] = 1'b0;
            exp_rd = 64'(32'h1000_0000 + 32'(t)) << (32 * exp_m);
            chk($sformatf("t4_bdone_%0d", t), 64'(m_bdone), 64'd1 << exp_m);
            chk($sformatf("t4_rdata_%0d", t), m_rdata, exp_rd);
            step();
            chk($sformatf("t4_idle_%0d", t), 64'(m_bdone), 64'd0);
        end

        // Silent slave: master 0 reads slave 1, which never answers in time.
        m_bstart  = 2'b01;
        m_addr[0] = 32'hF000_0020;
        step();
        chk("t5_s_bstart", 64'(s_bstart), 64'd1);
`ifdef BUS_TIMEOUT_EN
        repeat (16) step();
        chk("t5_pre_bdone", 64'(m_bdone), 64'd0);
        chk("t5_pre_ss",    64'(s_ss),    64'd2);
        step();
        chk("t5_tmo_bdone", 64'(m_bdone), 64'd1);
        chk("t5_tmo_berr",  64'(m_berr),  64'd1);
        chk("t5_tmo_rdata", m_rdata,      64'd0);
        chk("t5_tmo_ss",    64'(s_ss),    64'd0);
        s_bdone[1] = 1'b1;
        m_bstart   = '0;
        step();
        chk("t5_late_1", 64'(m_bdone), 64'd0);
        step();
        chk("t5_late_2", 64'(m_bdone), 64'd0);
        s_bdone = '0;
`else
        repeat (20) step();
        chk("t5_hold_bdone", 64'(m_bdone), 64'd0);
        chk("t5_hold_ss",    64'(s_ss),    64'd2);
        s_rdata[1] = 32'h7777_0000;
        s_bdone[1] = 1'b1;
        step();
        chk("t5_bdone", 64'(m_bdone), 64'd1);
        chk("t5_berr",  64'(m_berr),  64'd0);
        chk("t5_rdata", m_rdata,      {32'h0, 32'h7777_0000});
        s_bdone  = '0;
        m_bstart = '0;
        step();
        chk("t5_idle", 64'(m_bdone), 64'd0);
`endif

        // Reset in WAIT of a write by master 1; afterwards master 0 wins first.
        m_bstart   = 2'b10;
        m_addr[1]  = 32'h0000_0008;
        m_ttype[1] = 1'b1;
        m_tsize[1] = 2'd1;
        m_wdata[1] = 32'h0000_5A5A;
        step();
        chk("t6_req_ss",  64'(s_ss), 64'd1);
        step();
        chk("t6_wait_ss", 64'(s_ss), 64'd1);
        rst = 1'b1;
        step();
        chk_idle_outputs("t6_rst");
        rst        = 1'b0;
        m_bstart   = 2'b11;
        m_addr[0]  = 32'hF000_0030;
        m_ttype[0] = 1'b0;
        m_tsize[0] = 2'd2;
        s_rdata[1] = 32'hCAFE_0001;
        step();
        chk("t6_m0_ss",   64'(s_ss),   64'd2);
        chk("t6_m0_addr", 64'(s_addr), 64'hF000_0030);
        s_bdone[1] = 1'b1;
        step();
        chk("t6_m0_bdone", 64'(m_bdone), 64'd1);
        chk("t6_m0_rdata", m_rdata,      {32'h0, 32'hCAFE_0001});
        s_bdone     = '0;
        m_bstart[0] = 1'b0;
        step();
        step();
        chk("t6_m1_ss",    64'(s_ss),    64'd1);
        chk("t6_m1_addr",  64'(s_addr),  64'h8);
        chk("t6_m1_wdata", 64'(s_wdata), 64'h5A5A);
        chk("t6_m1_ttype", 64'(s_ttype), 64'd1);
        s_bdone[0] = 1'b1;
        step();
        chk("t6_m1_bdone", 64'(m_bdone), 64'd2);
        chk("t6_m1_berr",  64'(m_berr),  64'd0);
        chk("t6_m1_rdata", m_rdata,      64'd0);
        s_bdone  = '0;
        m_bstart = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_interconnect_mn.md
# bus_interconnect_mn

Parametrised shared-bus interconnect joining `N_MASTERS` bus masters (core I-bus/D-bus ports, debug, DMA) to `N_SLAVES` bus slaves (memories, peripherals) through one arbitrated transaction path. It adds three things a fixed 1:1 interconnect lacks:
- round-robin arbitration between masters;
- parametrised base/mask address decode per slave;
- an explicit error response (`m_berr`) for unmapped addresses.

It sits between the core/master bus ports and the slave ports in the SoC top.

## Interface
Parameters:
- `N_MASTERS`, 2: number of requesting masters (≥1).
- `N_SLAVES`, 2: number of slaves (≥1).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `SLAVE_BASE`, `{32'h0000_0000, 32'hF000_0000}`: per-slave base address, `[N_SLAVES][ADDR_W]`.
- `SLAVE_MASK`, `{32'hF000_0000, 32'hF000_0000}`: per-slave match mask.
- `TIMEOUT_CYCLES`, 16: watchdog limit, used only with `BUS_TIMEOUT_EN`.

Ports (all outputs registered unless stated):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m_bstart` in `[N_MASTERS]`: request level per master; held until that master's `m_bdone`.
- `m_addr` in `[N_MASTERS][ADDR_W]`: request address.
- `m_ttype` in `[N_MASTERS]`: transfer type, `READ`/`WRITE`.
- `m_tsize` in `[N_MASTERS][2]`: transfer size, `BYTE`/`HALFWORD`/`WORD`.
- `m_wdata` in `[N_MASTERS][DATA_W]`: write data.
- `m_rdata` out `[N_MASTERS][DATA_W]`: read data, valid while `m_bdone`.
- `m_bdone` out `[N_MASTERS]`: one-cycle completion pulse.
- `m_berr` out `[N_MASTERS]`: error flag, qualified by `m_bdone`.
- `s_ss` out `[N_SLAVES]`: one-hot slave select, held for the whole transaction.
- `s_bstart` out 1: one-cycle start pulse to the selected slave.
- `s_addr`, `s_ttype`, `s_tsize`, `s_wdata` out: latched request, broadcast to all slaves.
- `s_rdata` in `[N_SLAVES][DATA_W]`: slave read data.
- `s_bdone` in `[N_SLAVES]`: slave completion; sampled only from the selected slave.

## Operation
Only one transaction is in flight at a time.

State machine:
- **IDLE**: if any `m_bstart` is high:
  - Arbitrate round-robin, searching from (last grant + 1) mod `N_MASTERS`.
  - Latch the winner's addr/ttype/tsize/wdata and the winner index.
  - Decode the latched address.
  - Go to **ERR** if no slave matches, else to **REQ**.
- **REQ**:
  - `s_ss` = decoded one-hot; `s_bstart` = 1 for this cycle only.
  - Go to **WAIT**.
- **WAIT**:
  - Hold `s_ss`.
  - On `s_bdone[sel]`: capture `s_rdata[sel]`, go to **RESP**.
- **ERR**: go to **RESP** with `berr` = 1 and rdata = 0.
- **RESP**:
  - Pulse `m_bdone[grant]` and drive `m_berr[grant]`.
  - `m_rdata[grant]` = captured data; rdata is 0 for writes.
  - Drop `s_ss`, update the last-grant pointer, return to **IDLE**.

Decode rule:
- Slave i matches when `(addr & SLAVE_MASK[i]) == SLAVE_BASE[i]`.
- If several slaves match, the lowest index wins.

Boundary rules:
- A master that deasserts `m_bstart` after grant does not abort; the transaction completes and `m_bdone` still pulses.
- `s_bdone` from a non-selected slave is ignored, in every state.
- `s_bdone` arriving in **REQ** (same cycle as `s_bstart`) is accepted: WAIT is skipped and the FSM goes straight to **RESP**.
- Non-granted masters stay pending, with no output change, until granted.
- Reset mid-transaction:
  - FSM returns to **IDLE** and all outputs go to 0.
  - Last-grant pointer resets to `N_MASTERS-1`, so master 0 wins first.
  - The in-flight slave access is abandoned without a response.

## Timing
- Reset values: `m_rdata`, `m_bdone`, `m_berr`, `s_ss`, `s_bstart`, `s_addr`, `s_ttype`, `s_tsize`, `s_wdata` are all 0.
- Latency is counted from the first edge that samples `m_bstart` in IDLE:
  - `s_bstart` is high in cycle 1.
  - With a zero-wait slave (`s_bdone` in cycle 1), `m_bdone` is high in cycle 2.
  - Each slave wait state adds one cycle.
  - Decode error: `m_bdone`/`m_berr` high in cycle 2.
- Back-to-back: the next grant is sampled in the cycle after RESP (IDLE), so the minimum issue interval is 3 cycles.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - A counter clears on REQ and increments in WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no `s_bdone[sel]`, the FSM goes to RESP with `berr` = 1 and rdata = 0.
  - `s_ss` drops in that RESP cycle.
  - An `s_bdone` arriving later is ignored.
- `BUS_TIMEOUT_EN` undefined: no counter; WAIT lasts indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `bus_pkg`:
  - `ttype_e` (`READ`=0, `WRITE`=1).
  - `tsize_e` (`BYTE`=0, `HALFWORD`=1, `WORD`=2).
  - `ic_state_e` (IDLE, REQ, WAIT, ERR, RESP).
- Sub-module `rr_arbiter #(N)`:
  - Inputs: request vector, last-grant pointer.
  - Outputs: one-hot grant, grant index, `any`.
  - Purely combinational; the pointer register lives in the parent.

## Test plan
- **Reset**: `rst` pulse during WAIT of a write → all outputs 0 the next cycle; next request from master 1 alone is served normally.
- **Zero-wait read**: master 0 reads `0xF000_0010` (WORD); slave 1 returns `0xDEADBEEF` with `s_bdone` in the `s_bstart` cycle → `s_ss`=`2'b10`; `m_bdone[0]` and `m_rdata[0]`=`0xDEADBEEF` 2 cycles after request; `m_berr`=0.
- **Round-robin**: both masters hold `m_bstart` continuously, slave has 1 wait state → grants alternate 0,1,0,1; each `m_bdone` is 4 cycles apart.
- **Decode error**: read of `0x8000_0000` → no `s_ss`/`s_bstart` activity; `m_bdone`=1, `m_berr`=1, `m_rdata`=0 in cycle 2.
- **Timeout** (`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): slave never answers → `m_berr`=1 after 16 WAIT cycles; a late `s_bdone` causes no second `m_bdone`.
- **Write path**: master 1 writes HALFWORD `0x0000_A5A5` to `0x0000_0004` → `s_addr`/`s_wdata`/`s_tsize` match and are stable from `s_bstart` until `s_bdone`; `m_rdata[1]`=0.
